// File: rtl/lap_stopwatch.sv
// BCD lap stopwatch: IDLE/RUN/PAUSE/SPLIT control, 0.01 s digit chain and full-scale wrap pulse.
// Define LAP_STOPWATCH_LAP_EN to build the show-ahead lap FIFO and the SPLIT display freeze.
module lap_stopwatch #(
    parameter int CLK_HZ     = 50000000,
    parameter int NUM_DIGITS = 6,
    parameter int LAP_DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_pause,
    input  logic                    clear,
    input  logic                    lap,
    input  logic                    lap_rd,
    output logic [4*NUM_DIGITS-1:0] time_bcd,
    output logic [4*NUM_DIGITS-1:0] disp_bcd,
    output logic [1:0]              state,
    output logic                    overflow,
    output logic [4*NUM_DIGITS-1:0] lap_data,
    output logic [4:0]              lap_count,
    output logic                    lap_full,
    output logic                    lap_ovf
);
    localparam int TW      = 4 * NUM_DIGITS;
    localparam int PRE_MAX = CLK_HZ / 100 - 1;
    localparam int PRE_W   = (PRE_MAX > 0) ? $clog2(PRE_MAX + 1) : 1;
    localparam logic [PRE_W-1:0] PRE_TC = PRE_W'(PRE_MAX);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_SPLIT = 2'b11
    } state_e;

    // Seconds tens and minutes tens roll over after 5; every other digit after 9.
    function automatic logic [3:0] digit_max(input int idx);
        if ((idx == 3) || (idx == 5)) begin
            return 4'd5;
        end else begin
            return 4'd9;
        end
    endfunction

    state_e            state_q, state_d;
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [TW-1:0]     time_q, time_d, time_inc_s;
    logic [TW-1:0]     disp_q, disp_d;
    logic              ovf_q, ovf_d;
    logic              running_s, tick_s, carry_s, capture_s, lap_s;

`ifdef LAP_STOPWATCH_LAP_EN
    assign lap_s = lap;
`else
    logic unused_s;
    assign lap_s    = 1'b0;
    assign unused_s = lap ^ lap_rd;
`endif

    assign running_s = (state_q == ST_RUN) || (state_q == ST_SPLIT);
    assign tick_s    = running_s && (pre_q == PRE_TC);

    // Ripple +1 through the digit chain; carry out of the top digit means full scale.
    always_comb begin
        time_inc_s = time_q;
        carry_s    = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (carry_s) begin
                if (time_q[4*i +: 4] == digit_max(i)) begin
                    time_inc_s[4*i +: 4] = 4'd0;
                end else begin
                    time_inc_s[4*i +: 4] = time_q[4*i +: 4] + 4'd1;
                    carry_s              = 1'b0;
                end
            end else begin
                time_inc_s[4*i +: 4] = time_q[4*i +: 4];
            end
        end
    end

    // Control FSM next state with clear > start_pause > lap priority.
    always_comb begin
        state_d   = state_q;
        capture_s = 1'b0;
        if (clear) begin
            state_d = ST_IDLE;
        end else if (start_pause) begin
            case (state_q)
                ST_IDLE:  state_d = ST_RUN;
                ST_RUN:   state_d = ST_PAUSE;
                ST_PAUSE: state_d = ST_RUN;
                ST_SPLIT: state_d = ST_RUN;
                default:  state_d = ST_IDLE;
            endcase
        end else if (lap_s && running_s) begin
            state_d   = ST_SPLIT;
            capture_s = 1'b1;
        end else begin
            state_d = state_q;
        end
    end

    // Prescaler, time, wrap pulse and display; a tick in the cycle that pauses still lands.
    always_comb begin
        pre_d  = pre_q;
        time_d = time_q;
        ovf_d  = 1'b0;
        disp_d = disp_q;
        if (clear) begin
            pre_d  = {PRE_W{1'b0}};
            time_d = {TW{1'b0}};
            ovf_d  = 1'b0;
        end else begin
            if (running_s) begin
                if (tick_s) begin
                    pre_d = {PRE_W{1'b0}};
                end else begin
                    pre_d = pre_q + PRE_W'(1'b1);
                end
            end else if (state_q == ST_PAUSE) begin
                pre_d = pre_q;
            end else begin
                pre_d = {PRE_W{1'b0}};
            end
            if (tick_s) begin
                time_d = time_inc_s;
            end else begin
                time_d = time_q;
            end
            ovf_d = tick_s && carry_s;
        end
        if (state_d == ST_SPLIT) begin
            if (capture_s) begin
                disp_d = time_q;
            end else begin
                disp_d = disp_q;
            end
        end else begin
            disp_d = time_d;
        end
    end

    // Control and time registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pre_q   <= {PRE_W{1'b0}};
            time_q  <= {TW{1'b0}};
            disp_q  <= {TW{1'b0}};
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            time_q  <= time_d;
            disp_q  <= disp_d;
            ovf_q   <= ovf_d;
        end
    end

    assign time_bcd = time_q;
    assign disp_bcd = disp_q;
    assign state    = state_q;
    assign overflow = ovf_q;

`ifdef LAP_STOPWATCH_LAP_EN
    localparam int PW = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(LAP_DEPTH - 1);
    localparam logic [4:0]    DEPTH_C  = 5'(LAP_DEPTH);

    // Circular pointer advance; depth need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == LAST_PTR) begin
            return {PW{1'b0}};
        end else begin
            return p + PW'(1'b1);
        end
    endfunction

    logic [TW-1:0] mem_q [LAP_DEPTH];
    logic [TW-1:0] mem_d [LAP_DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [4:0]    cnt_q, cnt_d;
    logic          full_q, full_d, lovf_q, lovf_d;
    logic [TW-1:0] head_q, head_d;
    logic          push_s, pop_s;

    // FIFO bookkeeping: a pop frees room for a same-cycle capture even when full.
    always_comb begin
        mem_d  = mem_q;
        wr_d   = wr_q;
        rd_d   = rd_q;
        cnt_d  = cnt_q;
        lovf_d = lovf_q;
        push_s = 1'b0;
        pop_s  = 1'b0;
        if (clear) begin
            wr_d   = {PW{1'b0}};
            rd_d   = {PW{1'b0}};
            cnt_d  = 5'd0;
            lovf_d = 1'b0;
        end else begin
            pop_s  = lap_rd && (cnt_q != 5'd0);
            push_s = capture_s && ((cnt_q != DEPTH_C) || pop_s);
            if (push_s) begin
                mem_d[wr_q] = time_q;
                wr_d        = ptr_inc(wr_q);
            end else begin
                wr_d = wr_q;
            end
            if (pop_s) begin
                rd_d = ptr_inc(rd_q);
            end else begin
                rd_d = rd_q;
            end
            case ({push_s, pop_s})
                2'b10:   cnt_d = cnt_q + 5'd1;
                2'b01:   cnt_d = cnt_q - 5'd1;
                default: cnt_d = cnt_q;
            endcase
            if (capture_s && !push_s) begin
                lovf_d = 1'b1;
            end else begin
                lovf_d = lovf_q;
            end
        end
        full_d = (cnt_d == DEPTH_C);
        if (cnt_d == 5'd0) begin
            head_d = {TW{1'b0}};
        end else begin
            head_d = mem_d[rd_d];
        end
    end

    // Lap FIFO registers; the head is pre-registered for show-ahead output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < LAP_DEPTH; i++) begin
                mem_q[i] <= {TW{1'b0}};
            end
            wr_q   <= {PW{1'b0}};
            rd_q   <= {PW{1'b0}};
            cnt_q  <= 5'd0;
            full_q <= 1'b0;
            lovf_q <= 1'b0;
            head_q <= {TW{1'b0}};
        end else begin
            mem_q  <= mem_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            full_q <= full_d;
            lovf_q <= lovf_d;
            head_q <= head_d;
        end
    end

    assign lap_data  = head_q;
    assign lap_count = cnt_q;
    assign lap_full  = full_q;
    assign lap_ovf   = lovf_q;
`else
    assign lap_data  = {TW{1'b0}};
    assign lap_count = 5'd0;
    assign lap_full  = 1'b0;
    assign lap_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_lap_stopwatch.sv
// Bench for lap_stopwatch: two instances (6 digits/4 laps, 4 digits/2 laps) against an
// integer-hundredths reference model, plus directed literal checks.
module tb_lap_stopwatch;
    localparam int CLK_HZ = 1000;
    localparam int PRE_N  = CLK_HZ / 100;

    logic        clk, rst_n, start_pause, clear, lap, lap_rd;
    logic [23:0] time_a, disp_a, data_a;
    logic [15:0] time_b, disp_b, data_b;
    logic [1:0]  state_a, state_b;
    logic        ovf_a, ovf_b, full_a, full_b, lovf_a, lovf_b;
    logic [4:0]  cnt_a, cnt_b;

    int errors = 0;
    int checks = 0;

    lap_stopwatch #(.CLK_HZ(CLK_HZ), .NUM_DIGITS(6), .LAP_DEPTH(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .start_pause(start_pause), .clear(clear), .lap(lap),
        .lap_rd(lap_rd), .time_bcd(time_a), .disp_bcd(disp_a), .state(state_a),
        .overflow(ovf_a), .lap_data(data_a), .lap_count(cnt_a), .lap_full(full_a),
        .lap_ovf(lovf_a));

    lap_stopwatch #(.CLK_HZ(CLK_HZ), .NUM_DIGITS(4), .LAP_DEPTH(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .start_pause(start_pause), .clear(clear), .lap(lap),
        .lap_rd(lap_rd), .time_bcd(time_b), .disp_bcd(disp_b), .state(state_b),
        .overflow(ovf_b), .lap_data(data_b), .lap_count(cnt_b), .lap_full(full_b),
        .lap_ovf(lovf_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: elapsed time as an integer number of hundredths.
    int     m_nd[2]    = '{6, 4};
    int     m_depth[2] = '{4, 2};
    int     m_st[2];
    int     m_pre[2];
    longint m_cnt[2];
    longint m_split[2];
    bit     m_ovfp[2];
    bit     m_lovf[2];
    longint m_fifo[2][16];
    int     m_n[2];

    function automatic longint radix(input int i);
        return ((i == 3) || (i == 5)) ? 64'd6 : 64'd10;
    endfunction

    function automatic longint full_scale(input int nd);
        longint p = 1;
        for (int i = 0; i < nd; i++) p = p * radix(i);
        return p;
    endfunction

    function automatic logic [31:0] to_bcd(input longint v, input int nd);
        logic [31:0] r = 32'd0;
        logic [31:0] d;
        for (int i = 0; i < nd; i++) begin
            d = 32'(v % radix(i));
            r = r | (d << (4 * i));
            v = v / radix(i);
        end
        return r;
    endfunction

    task automatic model_reset(input int m);
        m_st[m] = 0; m_pre[m] = 0; m_cnt[m] = 0; m_split[m] = 0;
        m_ovfp[m] = 1'b0; m_lovf[m] = 1'b0; m_n[m] = 0;
    endtask

    task automatic model_step(input int m, input bit sp, input bit clr, input bit lp,
                              input bit rd, input bit rs);
        bit running, tick, cap, pop;
`ifndef LAP_STOPWATCH_LAP_EN
        lp = 1'b0;
        rd = 1'b0;
`endif
        if (!rs || clr) begin
            model_reset(m);
            return;
        end
        running   = (m_st[m] == 1) || (m_st[m] == 3);
        tick      = running && (m_pre[m] == PRE_N - 1);
        m_ovfp[m] = tick && (m_cnt[m] == full_scale(m_nd[m]) - 1);
        if (running) m_pre[m] = tick ? 0 : m_pre[m] + 1;
        else if (m_st[m] != 2) m_pre[m] = 0;
        cap = 1'b0;
        if (sp) begin
            m_st[m] = (m_st[m] == 1) ? 2 : 1;
        end else if (lp && running) begin
            cap        = 1'b1;
            m_split[m] = m_cnt[m];
            m_st[m]    = 3;
        end
        pop = rd && (m_n[m] > 0);
        if (pop) begin
            for (int i = 0; i < 15; i++) m_fifo[m][i] = m_fifo[m][i+1];
            m_n[m]--;
        end
        if (cap) begin
            if (m_n[m] < m_depth[m]) begin
                m_fifo[m][m_n[m]] = m_cnt[m];
                m_n[m]++;
            end else begin
                m_lovf[m] = 1'b1;
            end
        end
        if (tick) m_cnt[m] = (m_cnt[m] + 1) % full_scale(m_nd[m]);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_inst(input int m, input logic [31:0] t, input logic [31:0] d,
                              input logic [31:0] ld, input logic [1:0] s, input logic o,
                              input logic [4:0] c, input logic f, input logic lo);
        logic [31:0] et;
        et = to_bcd(m_cnt[m], m_nd[m]);
        check($sformatf("inst%0d time_bcd", m), t, et);
        check($sformatf("inst%0d disp_bcd", m), d,
              (m_st[m] == 3) ? to_bcd(m_split[m], m_nd[m]) : et);
        check($sformatf("inst%0d state", m), 32'(s), 32'(m_st[m]));
        check($sformatf("inst%0d overflow", m), 32'(o), 32'(m_ovfp[m]));
        check($sformatf("inst%0d lap_data", m), ld,
              (m_n[m] > 0) ? to_bcd(m_fifo[m][0], m_nd[m]) : 32'd0);
        check($sformatf("inst%0d lap_count", m), 32'(c), 32'(m_n[m]));
        check($sformatf("inst%0d lap_full", m), 32'(f), 32'(m_n[m] == m_depth[m]));
        check($sformatf("inst%0d lap_ovf", m), 32'(lo), 32'(m_lovf[m]));
    endtask

    // Compare process: outputs vs model on every falling edge, then advance the model.
    initial begin
        model_reset(0);
        model_reset(1);
        forever begin
            @(negedge clk);
            check_inst(0, 32'(time_a), 32'(disp_a), 32'(data_a), state_a, ovf_a, cnt_a,
                       full_a, lovf_a);
            check_inst(1, 32'(time_b), 32'(disp_b), 32'(data_b), state_b, ovf_b, cnt_b,
                       full_b, lovf_b);
            model_step(0, start_pause, clear, lap, lap_rd, rst_n);
            model_step(1, start_pause, clear, lap, lap_rd, rst_n);
        end
    end

    task automatic drive(input bit sp, input bit clr, input bit lp, input bit rd);
        @(posedge clk);
        #1;
        start_pause = sp; clear = clr; lap = lp; lap_rd = rd;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rand_inputs();
        start_pause = 1'($urandom_range(0, 1));
        clear       = 1'($urandom_range(0, 1));
        lap         = 1'($urandom_range(0, 1));
        lap_rd      = 1'($urandom_range(0, 1));
    endtask

    // Bounded wait for a live time value on instance a (0) or b (1).
    task automatic wait_time(input string name, input int which, input logic [31:0] v,
                             input int bound);
        int k = 0;
        logic [31:0] cur;
        cur = (which == 0) ? 32'(time_a) : 32'(time_b);
        while ((cur !== v) && (k < bound)) begin
            idle(1);
            k++;
            cur = (which == 0) ? 32'(time_a) : 32'(time_b);
        end
        check(name, cur, v);
    endtask

    initial begin
        rst_n = 1'b0;
        rand_inputs();
        @(posedge clk); #1;
        rand_inputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
        start_pause = 1'b0; clear = 1'b0; lap = 1'b0; lap_rd = 1'b0;
        check("reset time_a", 32'(time_a), 32'h0);
        check("reset disp_a", 32'(disp_a), 32'h0);
        check("reset state_a", 32'(state_a), 32'h0);
        check("reset lap_count_a", 32'(cnt_a), 32'h0);
        check("reset lap_data_b", 32'(data_b), 32'h0);
        check("reset lap_ovf_b", 32'(lovf_b), 32'h0);

        // 250 ticks, pause on the 250th tick edge, hold 5000 cycles, resume.
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        idle(2499);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);
        check("pause state", 32'(state_a), 32'h2);
        idle(5000);
        check("pause hold time_a", 32'(time_a), 32'h000250);
        check("pause hold time_b", 32'(time_b), 32'h0250);
        check("pause hold state", 32'(state_b), 32'h2);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);
        check("resume state", 32'(state_a), 32'h1);
        check("resume time", 32'(time_a), 32'h000250);
        wait_time("reach 00:10.00", 0, 32'h001000, 7600);
        check("10s state", 32'(state_a), 32'h1);
        check("10s time_b", 32'(time_b), 32'h1000);

        // Full-scale wrap of the 4-digit instance.
        wait_time("reach 59.99", 1, 32'h5999, 50100);
        idle(9);
        check("pre-wrap time_b", 32'(time_b), 32'h5999);
        check("pre-wrap overflow_b", 32'(ovf_b), 32'h0);
        idle(1);
        check("wrap time_b", 32'(time_b), 32'h0000);
        check("wrap overflow_b", 32'(ovf_b), 32'h1);
        check("wrap time_a", 32'(time_a), 32'h010000);
        check("wrap overflow_a", 32'(ovf_a), 32'h0);
        idle(1);
        check("post-wrap overflow_b", 32'(ovf_b), 32'h0);
        check("post-wrap state_b", 32'(state_b), 32'h1);

`ifdef LAP_STOPWATCH_LAP_EN
        // Three laps at 1.00/2.00/3.00 s; depth-2 instance drops the third.
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        wait_time("reach 1.00", 0, 32'h000100, 1100);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        idle(1);
        check("lap1 state", 32'(state_a), 32'h3);
        check("lap1 disp_a", 32'(disp_a), 32'h000100);
        wait_time("reach 2.00", 0, 32'h000200, 1100);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        wait_time("reach 3.00", 0, 32'h000300, 1100);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        idle(1);
        check("lap3 full_b", 32'(full_b), 32'h1);
        check("lap3 ovf_b", 32'(lovf_b), 32'h1);
        check("lap3 disp_b", 32'(disp_b), 32'h0300);
        check("lap3 count_a", 32'(cnt_a), 32'h3);
        check("lap3 ovf_a", 32'(lovf_a), 32'h0);
        check("lap3 head_b", 32'(data_b), 32'h0100);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        idle(1);
        check("pop1 head_b", 32'(data_b), 32'h0200);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        idle(1);
        check("pop2 count_b", 32'(cnt_b), 32'h0);
        check("pop2 head_b", 32'(data_b), 32'h0);
        check("pop2 head_a", 32'(data_a), 32'h000300);

        // Capture plus pop while full: count unchanged, no drop.
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        idle(20);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        idle(1);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        idle(1);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        idle(1);
        check("lap+rd count_b", 32'(cnt_b), 32'h2);
        check("lap+rd ovf_b", 32'(lovf_b), 32'h0);
        check("lap+rd count_a", 32'(cnt_a), 32'h2);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        idle(5);
`else
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        idle(1);
        check("lap ignored state", 32'(state_a), 32'h1);
        check("lap ignored count", 32'(cnt_a), 32'h0);
`endif

        // Clear wins over start_pause during RUN.
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        idle(1);
        check("clear state", 32'(state_a), 32'h0);
        check("clear time", 32'(time_a), 32'h0);
        check("clear count_a", 32'(cnt_a), 32'h0);
        check("clear count_b", 32'(cnt_b), 32'h0);
        check("clear ovf_b", 32'(lovf_b), 32'h0);

        // Randomized traffic checked cycle by cycle against the model.
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #1;
            start_pause = ($urandom_range(39, 0) == 0);
            clear       = ($urandom_range(299, 0) == 0);
            lap         = ($urandom_range(19, 0) == 0);
            lap_rd      = ($urandom_range(11, 0) == 0);
            rst_n       = ($urandom_range(799, 0) != 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
